// File: rtl/prf_wr_arbiter.sv
// prf_wr_arbiter: zero-fills the PRF after reset, then round-robin shares NWPORT RAM write ports among NREQ writeback lanes.
// Latency: a write accepted at edge T is driven on we_o/addr_o/data_o right after T (registered), and the RAM commits it at T+1.
// Backpressure: req_ready_o is low during INIT, and also for lanes that lose arbitration or whose address was already granted this cycle.
module prf_wr_arbiter #(
    parameter int NREQ   = 4,
    parameter int NWPORT = 2,
    parameter int DEPTH  = 128,
    parameter int INDEX  = 7,
    parameter int WIDTH  = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_valid_i,
    input  logic [NREQ*INDEX-1:0]     req_addr_i,
    input  logic [NREQ*WIDTH-1:0]     req_data_i,
    output logic [NREQ-1:0]           req_ready_o,
    output logic [NWPORT-1:0]         we_o,
    output logic [NWPORT*INDEX-1:0]   addr_o,
    output logic [NWPORT*WIDTH-1:0]   data_o,
    output logic                      init_done_o
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [INDEX-1:0] LAST_CNT = INDEX'(DEPTH - NWPORT);
    localparam logic [INDEX-1:0] CNT_STEP = INDEX'(NWPORT);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [INDEX-1:0]  cnt;
    logic [INDEX-1:0]  cnt_nxt;
    logic [PTRW-1:0]   ptr;
    logic [PTRW-1:0]   ptr_nxt;
    logic              init_done_nxt;

    // Per-port view of this cycle's grants, in scan order.
    logic [NREQ-1:0]   gnt;
    logic [NWPORT-1:0] port_vld;
    logic [INDEX-1:0]  port_addr [NWPORT];
    logic [WIDTH-1:0]  port_data [NWPORT];

    // Sweep sequencing: step the fill counter in INIT; leave for RUN once the last slice is written.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        init_done_nxt = init_done_o;
        case (state)
            ST_INIT: begin
                cnt_nxt = cnt + CNT_STEP;
                if (cnt == LAST_CNT) begin
                    state_nxt     = ST_RUN;
                    init_done_nxt = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Round-robin scan starting at ptr. Up to NWPORT grants are made, and a lane whose
    // address matches an earlier grant is skipped so that no two ports hit the same entry.
    always_comb begin
        int               n;
        int               idx;
        int               last;
        logic             hit;
        logic [INDEX-1:0] a;
        n        = 0;
        idx      = 0;
        last     = 0;
        hit      = 1'b0;
        a        = '0;
        gnt      = '0;
        port_vld = '0;
        ptr_nxt  = ptr;
        for (int p = 0; p < NWPORT; p++) begin
            port_addr[p] = '0;
            port_data[p] = '0;
        end
        if (state == ST_RUN) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NREQ) begin
                    idx = idx - NREQ;
                end
                a   = req_addr_i[idx*INDEX +: INDEX];
                hit = 1'b0;
                for (int j = 0; j < NWPORT; j++) begin
                    if (j < n && port_addr[j] == a) begin
                        hit = 1'b1;
                    end
                end
                if (req_valid_i[idx] && n < NWPORT && !hit) begin
                    gnt[idx]     = 1'b1;
                    port_vld[n]  = 1'b1;
                    port_addr[n] = a;
                    port_data[n] = req_data_i[idx*WIDTH +: WIDTH];
                    last         = idx;
                    n            = n + 1;
                end
            end
            if (n != 0) begin
                ptr_nxt = (last == NREQ - 1) ? '0 : PTRW'(last + 1);
            end
        end
    end

    assign req_ready_o = gnt;

    // Control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_INIT;
            cnt         <= '0;
            ptr         <= '0;
            init_done_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ptr         <= ptr_nxt;
            init_done_o <= init_done_nxt;
        end
    end

    // RAM-side write registers. In INIT every port writes zero, and in RUN the granted ports write.
    // Idle ports keep their last address and data so the bus does not toggle needlessly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_o   <= '0;
            addr_o <= '0;
            data_o <= '0;
        end else if (state == ST_INIT) begin
            we_o   <= '1;
            data_o <= '0;
            for (int p = 0; p < NWPORT; p++) begin
                addr_o[p*INDEX +: INDEX] <= cnt + INDEX'(p);
            end
        end else begin
            for (int p = 0; p < NWPORT; p++) begin
                we_o[p] <= port_vld[p];
                if (port_vld[p]) begin
                    addr_o[p*INDEX +: INDEX] <= port_addr[p];
                    data_o[p*WIDTH +: WIDTH] <= port_data[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_prf_wr_arbiter.sv
// tb_prf_wr_arbiter: directed and randomised checks of the PRF write-port arbiter.
// Latency: outputs are sampled 1 time unit after each posedge; ready is sampled before the edge.
// Backpressure: lanes hold valid/addr/data until the bench sees ready at the edge.
module tb_prf_wr_arbiter;

    localparam int NREQ   = 4;
    localparam int NWPORT = 2;
    localparam int DEPTH  = 128;
    localparam int INDEX  = 7;
    localparam int WIDTH  = 64;
    localparam int SWEEP  = DEPTH / NWPORT;

    logic                     clk;
    logic                     reset_n;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*INDEX-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0]    req_data;
    logic [NREQ-1:0]          req_ready;
    logic [NWPORT-1:0]        we;
    logic [NWPORT*INDEX-1:0]  addr;
    logic [NWPORT*WIDTH-1:0]  data;
    logic                     init_done;

    int checks;
    int errors;

    logic [WIDTH-1:0] exp_ram [DEPTH];
    logic [WIDTH-1:0] act_ram [DEPTH];

    prf_wr_arbiter #(
        .NREQ(NREQ), .NWPORT(NWPORT), .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .we_o        (we),
        .addr_o      (addr),
        .data_o      (data),
        .init_done_o (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int r, input logic v, input logic [INDEX-1:0] a, input logic [WIDTH-1:0] d);
        req_valid[r]               = v;
        req_addr[r*INDEX +: INDEX] = a;
        req_data[r*WIDTH +: WIDTH] = d;
    endtask

    // Reset, run the full sweep while mirroring writes into act_ram, and leave time at posedge+1.
    task automatic fresh_start();
        req_valid = '0;
        reset_n   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (SWEEP) begin
            @(posedge clk);
            #1;
            for (int p = 0; p < NWPORT; p++)
                if (we[p]) act_ram[addr[p*INDEX +: INDEX]] = data[p*WIDTH +: WIDTH];
        end
        checks++;
        if (init_done !== 1'b1) begin
            errors++; $display("FAIL init_done_after_sweep act=%b exp=1", init_done);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        for (int r = 0; r < NREQ; r++) set_req(r, 1'b1, INDEX'(r), 64'h55);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (we !== 2'b00) begin errors++; $display("FAIL reset_we act=%b exp=00", we); end
        checks++; if (addr !== '0) begin errors++; $display("FAIL reset_addr act=%h exp=0", addr); end
        checks++; if (data !== '0) begin errors++; $display("FAIL reset_data act=%h exp=0", data); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done act=%b exp=0", init_done); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready act=%b exp=0000", req_ready); end
        repeat (2) @(posedge clk);
    endtask

    // Lanes stay valid during the sweep to show that ready is held low throughout INIT.
    task automatic test_init();
        logic [NWPORT*INDEX-1:0] ea;
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 0; e < SWEEP; e++) begin
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL init_ready e=%0d act=%b exp=0000", e, req_ready); end
            @(posedge clk);
            #1;
            ea[0 +: INDEX]     = INDEX'(2 * e);
            ea[INDEX +: INDEX] = INDEX'(2 * e + 1);
            checks++; if (we !== 2'b11) begin errors++; $display("FAIL init_we e=%0d act=%b exp=11", e, we); end
            checks++; if (addr !== ea) begin errors++; $display("FAIL init_addr e=%0d act=%h exp=%h", e, addr, ea); end
            checks++; if (data !== '0) begin errors++; $display("FAIL init_data e=%0d act=%h exp=0", e, data); end
            checks++;
            if (init_done !== (e == SWEEP - 1)) begin
                errors++; $display("FAIL init_done e=%0d act=%b exp=%b", e, init_done, (e == SWEEP - 1));
            end
        end
        req_valid = '0;
        @(posedge clk);
        #1;
        ea[0 +: INDEX]     = INDEX'(126);
        ea[INDEX +: INDEX] = INDEX'(127);
        checks++; if (we !== 2'b00) begin errors++; $display("FAIL post_init_we act=%b exp=00", we); end
        checks++; if (addr !== ea) begin errors++; $display("FAIL post_init_addr_hold act=%h exp=%h", addr, ea); end
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL post_init_done act=%b exp=1", init_done); end
    endtask

    task automatic test_round_robin();
        fresh_start();
        for (int r = 0; r < NREQ; r++) set_req(r, 1'b1, INDEX'(10 + r), 64'h1000 + 64'(r));
        #1;
        checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL rr_c1_ready act=%b exp=0011", req_ready); end
        @(posedge clk); #1;
        checks++; if (we !== 2'b11) begin errors++; $display("FAIL rr_c1_we act=%b exp=11", we); end
        checks++; if (addr !== {7'd11, 7'd10}) begin errors++; $display("FAIL rr_c1_addr act=%h exp=%h", addr, {7'd11, 7'd10}); end
        checks++; if (data !== {64'h1001, 64'h1000}) begin errors++; $display("FAIL rr_c1_data act=%h exp=%h", data, {64'h1001, 64'h1000}); end
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        #1;
        checks++; if (req_ready !== 4'b1100) begin errors++; $display("FAIL rr_c2_ready act=%b exp=1100", req_ready); end
        @(posedge clk); #1;
        checks++; if (we !== 2'b11) begin errors++; $display("FAIL rr_c2_we act=%b exp=11", we); end
        checks++; if (addr !== {7'd13, 7'd12}) begin errors++; $display("FAIL rr_c2_addr act=%h exp=%h", addr, {7'd13, 7'd12}); end
        checks++; if (data !== {64'h1003, 64'h1002}) begin errors++; $display("FAIL rr_c2_data act=%h exp=%h", data, {64'h1003, 64'h1002}); end
        req_valid = '0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_idle_ready act=%b exp=0000", req_ready); end
        @(posedge clk); #1;
        checks++; if (we !== 2'b00) begin errors++; $display("FAIL rr_idle_we act=%b exp=00", we); end
    endtask

    task automatic test_conflict();
        fresh_start();
        set_req(1, 1'b1, INDEX'(5), 64'hA1);
        set_req(2, 1'b1, INDEX'(5), 64'hA2);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL conf_c1_ready act=%b exp=0010", req_ready); end
        @(posedge clk); #1;
        checks++; if (we !== 2'b01) begin errors++; $display("FAIL conf_c1_we act=%b exp=01", we); end
        checks++; if (addr[0 +: INDEX] !== 7'd5) begin errors++; $display("FAIL conf_c1_addr act=%0d exp=5", addr[0 +: INDEX]); end
        checks++; if (data[0 +: WIDTH] !== 64'hA1) begin errors++; $display("FAIL conf_c1_data act=%h exp=a1", data[0 +: WIDTH]); end
        set_req(1, 1'b0, '0, '0);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL conf_c2_ready act=%b exp=0100", req_ready); end
        @(posedge clk); #1;
        checks++; if (we !== 2'b01) begin errors++; $display("FAIL conf_c2_we act=%b exp=01", we); end
        checks++; if (addr[0 +: INDEX] !== 7'd5) begin errors++; $display("FAIL conf_c2_addr act=%0d exp=5", addr[0 +: INDEX]); end
        checks++; if (data[0 +: WIDTH] !== 64'hA2) begin errors++; $display("FAIL conf_c2_data act=%h exp=a2", data[0 +: WIDTH]); end
        req_valid = '0;
    endtask

    task automatic test_single();
        fresh_start();
        set_req(3, 1'b1, INDEX'(20), 64'hDEAD);
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL single_ready act=%b exp=1000", req_ready); end
        @(posedge clk); #1;
        checks++; if (we !== 2'b01) begin errors++; $display("FAIL single_we act=%b exp=01", we); end
        checks++; if (addr[0 +: INDEX] !== 7'd20) begin errors++; $display("FAIL single_addr act=%0d exp=20", addr[0 +: INDEX]); end
        checks++; if (data[0 +: WIDTH] !== 64'hDEAD) begin errors++; $display("FAIL single_data act=%h exp=dead", data[0 +: WIDTH]); end
        checks++; if (addr[INDEX +: INDEX] !== 7'd127) begin errors++; $display("FAIL single_port1_hold act=%0d exp=127", addr[INDEX +: INDEX]); end
        // With ptr back at 0, all four lanes valid must grant r0 and r1.
        for (int r = 0; r < NREQ; r++) set_req(r, 1'b1, INDEX'(30 + r), 64'(r));
        #1;
        checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL single_ptr_wrap act=%b exp=0011", req_ready); end
        req_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        req_valid = '0;
        reset_n   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (addr[0 +: INDEX] !== 7'd38) begin errors++; $display("FAIL mid_pre_addr act=%0d exp=38", addr[0 +: INDEX]); end
        for (int r = 0; r < NREQ; r++) set_req(r, 1'b1, INDEX'(r), 64'h77);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (we !== 2'b00) begin errors++; $display("FAIL mid_we act=%b exp=00", we); end
        checks++; if (addr !== '0) begin errors++; $display("FAIL mid_addr act=%h exp=0", addr); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL mid_init_done act=%b exp=0", init_done); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready act=%b exp=0000", req_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        req_valid = '0;
        for (int e = 0; e < SWEEP; e++) begin
            @(posedge clk); #1;
            if (e == 0) begin
                checks++;
                if (addr !== {7'd1, 7'd0}) begin errors++; $display("FAIL mid_restart_addr act=%h exp=%h", addr, {7'd1, 7'd0}); end
            end
            if (e >= SWEEP - 2) begin
                checks++;
                if (init_done !== (e == SWEEP - 1)) begin
                    errors++; $display("FAIL mid_done_edge e=%0d act=%b exp=%b", e, init_done, (e == SWEEP - 1));
                end
            end
        end
    endtask

    // Random traffic against a RAM model. Disjoint per-lane address pools allow a strict
    // starvation bound; a shared tiny pool stresses the same-address skip instead.
    task automatic test_random(input bit shared, input int cycles);
        logic [NREQ-1:0]  vld;
        logic [NREQ-1:0]  acc;
        logic [INDEX-1:0] a [NREQ];
        logic [WIDTH-1:0] d [NREQ];
        int               wait_c [NREQ];
        int               n_acc;
        int               n_we;
        bit               dup;
        vld = '0;
        for (int r = 0; r < NREQ; r++) begin
            a[r] = '0; d[r] = '0; wait_c[r] = 0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            exp_ram[i] = '0;
            act_ram[i] = '1;
        end
        fresh_start();
        for (int c = 0; c < cycles; c++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!vld[r] && $urandom_range(9, 0) < 6) begin
                    vld[r] = 1'b1;
                    a[r]   = shared ? INDEX'($urandom_range(3, 0)) : INDEX'($urandom_range(31, 0) * NREQ + r);
                    d[r]   = WIDTH'({$urandom, $urandom});
                end
                set_req(r, vld[r], a[r], d[r]);
            end
            #1;
            checks++;
            if ((req_ready & ~vld) !== '0) begin
                errors++; $display("FAIL rnd_ready_without_valid c=%0d act=%b valid=%b", c, req_ready, vld);
            end
            acc   = req_ready & vld;
            n_acc = 0;
            for (int r = 0; r < NREQ; r++) begin
                if (acc[r]) begin
                    exp_ram[a[r]] = d[r];
                    n_acc++;
                end
                if (!shared) begin
                    wait_c[r] = (vld[r] && !acc[r]) ? wait_c[r] + 1 : 0;
                    checks++;
                    if (wait_c[r] > 2) begin
                        errors++; $display("FAIL rnd_starve c=%0d r=%0d act=%0d exp<=2", c, r, wait_c[r]);
                    end
                end
            end
            @(posedge clk); #1;
            n_we = 0;
            dup  = 1'b0;
            for (int p = 0; p < NWPORT; p++) begin
                if (we[p]) begin
                    n_we++;
                    act_ram[addr[p*INDEX +: INDEX]] = data[p*WIDTH +: WIDTH];
                    for (int q = p + 1; q < NWPORT; q++)
                        if (we[q] && addr[q*INDEX +: INDEX] == addr[p*INDEX +: INDEX]) dup = 1'b1;
                end
            end
            checks++;
            if (n_we != n_acc) begin errors++; $display("FAIL rnd_write_count c=%0d act=%0d exp=%0d", c, n_we, n_acc); end
            checks++;
            if (dup) begin errors++; $display("FAIL rnd_dup_addr c=%0d act=%h exp=distinct", c, addr); end
            vld = vld & ~acc;
        end
        req_valid = '0;
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (act_ram[i] !== exp_ram[i]) begin
                errors++; $display("FAIL rnd_ram addr=%0d act=%h exp=%h", i, act_ram[i], exp_ram[i]);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        test_reset();
        test_init();
        test_round_robin();
        test_conflict();
        test_single();
        test_reset_mid();
        test_random(1'b0, 5000);
        test_random(1'b1, 5000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
